// File: rtl/conv_window_gen_5x5.sv
// Streaming 5x5 sliding-window generator: four line buffers feed a 5x5 shift register window.
// Optional macro CONV_WIN_COORD_EN adds win_x/win_y window top-left coordinate outputs.
module conv_window_gen_5x5 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic signed [DATA_WIDTH-1:0] pix_data,
    output logic [25*DATA_WIDTH-1:0]     win_flat,
    output logic                         win_valid,
    output logic                         frame_done
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0]     win_x,
    output logic [$clog2(IMG_H)-1:0]     win_y
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(4);

    typedef logic signed [DATA_WIDTH-1:0] pix_t;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;

    pix_t lb_mem  [4][IMG_W];
    pix_t lb_rd   [4];
    pix_t new_col [5];
    pix_t win_q   [5][5];

    // Pixels presented while reset is held are dropped entirely.
    assign accept = pix_valid & rst_n;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            win_valid_d  = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // lb0 holds row-1 ... lb3 holds row-4, all at the current column index.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lb_rd[k] = lb_mem[k][col_q];
        end
        new_col[0] = lb_rd[3];
        new_col[1] = lb_rd[2];
        new_col[2] = lb_rd[1];
        new_col[3] = lb_rd[0];
        new_col[4] = pix_data;
    end

    // NOTE: line buffers are deliberately not reset; every entry is rewritten in-frame before a window uses it.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mem[0][col_q] <= pix_data;
            for (int k = 1; k < 4; k++) begin
                lb_mem[k][col_q] <= lb_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][4] <= new_col[r];
            end
        end
    end

    for (genvar r = 0; r < 5; r++) begin : g_row
        for (genvar c = 0; c < 5; c++) begin : g_col
            assign win_flat[(r*5+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef CONV_WIN_COORD_EN
    logic [COL_W-1:0] win_x_q;
    logic [ROW_W-1:0] win_y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else if (win_valid_d) begin
            win_x_q <= col_q - COL_FIRST;
            win_y_q <= row_q - ROW_FIRST;
        end
    end

    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

endmodule

// File: tb/tb_conv_window_gen_5x5.sv
// Scoreboard bench for conv_window_gen_5x5: a frame-image model predicts every window at drive time.
// A second instance covers the small 5x6 geometry; coordinates are checked when CONV_WIN_COORD_EN is set.
module tb_conv_window_gen_5x5;

    localparam int DW = 8;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int SW = 5;
    localparam int SH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              pix_valid;
    logic [DW-1:0]     pix_data;
    logic [25*DW-1:0]  win_flat;
    logic              win_valid;
    logic              frame_done;

    logic              s_pix_valid;
    logic [DW-1:0]     s_pix_data;
    logic [25*DW-1:0]  s_win_flat;
    logic              s_win_valid;
    logic              s_frame_done;

`ifdef CONV_WIN_COORD_EN
    logic [$clog2(W)-1:0]  win_x;
    logic [$clog2(H)-1:0]  win_y;
    logic [$clog2(SW)-1:0] s_win_x;
    logic [$clog2(SH)-1:0] s_win_y;
`endif

    conv_window_gen_5x5 #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .win_flat   (win_flat),
        .win_valid  (win_valid),
        .frame_done (frame_done)
`ifdef CONV_WIN_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    conv_window_gen_5x5 #(.DATA_WIDTH(DW), .IMG_W(SW), .IMG_H(SH)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (s_pix_valid),
        .pix_data   (s_pix_data),
        .win_flat   (s_win_flat),
        .win_valid  (s_win_valid),
        .frame_done (s_frame_done)
`ifdef CONV_WIN_COORD_EN
        ,
        .win_x      (s_win_x),
        .win_y      (s_win_y)
`endif
    );

    typedef struct {
        logic [25*DW-1:0] flat;
        logic             done;
        int               x;
        int               y;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] img [H][W];
    int m_col = 0;
    int m_row = 0;

    int n_win, n_done, pix_idx, first_idx;
    logic first_seen;
    logic [25*DW-1:0] first_flat;

    function automatic logic [DW-1:0] px(input logic [25*DW-1:0] f, input int r, input int c);
        return f[(r*5+c)*DW +: DW];
    endfunction

    task automatic clear_stats();
        n_win      = 0;
        n_done     = 0;
        pix_idx    = 0;
        first_idx  = -1;
        first_seen = 1'b0;
        first_flat = '0;
    endtask

    // One clock: drive inputs, model the accept at the edge, compare outputs 1 time unit later.
    task automatic step(input logic v, input logic [DW-1:0] d);
        logic exp_v;
        logic exp_done;
        exp_t e;
        pix_valid = v;
        pix_data  = d;
        @(posedge clk);
        exp_v    = 1'b0;
        exp_done = 1'b0;
        if (!rst_n) begin
            m_col = 0;
            m_row = 0;
        end else if (v) begin
            img[m_row][m_col] = d;
            if (m_row >= 4 && m_col >= 4) begin
                e.flat = '0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.flat[(i*5+j)*DW +: DW] = img[m_row-4+i][m_col-4+j];
                e.done = (m_row == H-1) && (m_col == W-1);
                e.x    = m_col - 4;
                e.y    = m_row - 4;
                sb.push_back(e);
                exp_v = 1'b1;
            end
            exp_done = (m_row == H-1) && (m_col == W-1);
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
            pix_idx++;
        end
        #1;
        total++;
        if (win_valid !== exp_v) begin
            bad++;
            $display("FAIL win_valid at pix_idx=%0d: got %b want %b", pix_idx, win_valid, exp_v);
        end
        total++;
        if (frame_done !== exp_done) begin
            bad++;
            $display("FAIL frame_done at pix_idx=%0d: got %b want %b", pix_idx, frame_done, exp_done);
        end
        if (win_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_window at pix_idx=%0d: got window want none", pix_idx);
            end else begin
                e = sb.pop_front();
                total++;
                if (win_flat !== e.flat) begin
                    bad++;
                    $display("FAIL win_flat window %0d: got %h want %h", n_win, win_flat, e.flat);
                end
`ifdef CONV_WIN_COORD_EN
                total++;
                if (int'(win_x) !== e.x || int'(win_y) !== e.y) begin
                    bad++;
                    $display("FAIL win_xy window %0d: got (%0d,%0d) want (%0d,%0d)",
                             n_win, win_x, win_y, e.x, e.y);
                end
`endif
                n_win++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_idx  = pix_idx - 1;
                    first_flat = win_flat;
                end
            end
        end
        if (frame_done === 1'b1) n_done++;
    endtask

    // mode 0: ramp ((r*W+c)+offset) mod 128; mode 1: random signed values.
    task automatic send_frame(input int mode, input int offset, input bit gaps, input int npix);
        logic [DW-1:0] p;
        for (int k = 0; k < npix; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) step(1'b0, DW'($urandom));
            end
            if (mode == 0) p = DW'((k % (W*H) + offset) % 128);
            else           p = DW'($urandom);
            step(1'b1, p);
        end
    endtask

    task automatic check_scalar(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_sb_empty(input string name);
        check_scalar(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 8'h55);
        step(1'b1, 8'hAA);
        total++;
        if (win_flat !== '0) begin
            bad++;
            $display("FAIL reset_win_flat: got %h want 0", win_flat);
        end
        rst_n = 1'b1;
        step(1'b0, 8'h00);
    endtask

    task automatic test_ramp();
        clear_stats();
        send_frame(0, 0, 1'b0, W*H);
        check_scalar("ramp_first_idx", first_idx, 116);
        check_scalar("ramp_p00", int'(px(first_flat, 0, 0)), 0);
        check_scalar("ramp_p04", int'(px(first_flat, 0, 4)), 4);
        check_scalar("ramp_p40", int'(px(first_flat, 4, 0)), 112);
        check_scalar("ramp_p44", int'(px(first_flat, 4, 4)), 116);
        check_scalar("ramp_windows", n_win, 576);
        check_scalar("ramp_frame_done", n_done, 1);
        check_sb_empty("ramp_sb_empty");
    endtask

    task automatic test_random_duty();
        clear_stats();
        send_frame(0, 0, 1'b1, W*H);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check_scalar("duty_windows", n_win, 576);
        check_scalar("duty_frame_done", n_done, 1);
        check_scalar("duty_p44", int'(px(first_flat, 4, 4)), 116);
        check_sb_empty("duty_sb_empty");
    endtask

    task automatic test_back_to_back();
        clear_stats();
        send_frame(0, 0, 1'b0, W*H);
        check_scalar("b2b_f1_windows", n_win, 576);
        clear_stats();
        send_frame(0, 1, 1'b0, W*H);
        check_scalar("b2b_f2_p00", int'(px(first_flat, 0, 0)), 1);
        check_scalar("b2b_f2_p44", int'(px(first_flat, 4, 4)), 117);
        check_scalar("b2b_f2_windows", n_win, 576);
        check_scalar("b2b_f2_frame_done", n_done, 1);
        check_sb_empty("b2b_sb_empty");
    endtask

    task automatic test_signed_frame();
        clear_stats();
        send_frame(1, 0, 1'b1, W*H);
        check_scalar("signed_windows", n_win, 576);
        check_sb_empty("signed_sb_empty");
    endtask

    task automatic test_reset_midframe();
        clear_stats();
        send_frame(0, 0, 1'b0, 300);
        check_sb_empty("mid_sb_before_reset");
        rst_n = 1'b0;
        step(1'b1, 8'h7F);
        total++;
        if (win_flat !== '0) begin
            bad++;
            $display("FAIL mid_reset_win_flat: got %h want 0", win_flat);
        end
        rst_n = 1'b1;
        clear_stats();
        send_frame(0, 0, 1'b0, W*H);
        check_scalar("mid_windows", n_win, 576);
        check_scalar("mid_p00", int'(px(first_flat, 0, 0)), 0);
        check_scalar("mid_first_idx", first_idx, 116);
        check_sb_empty("mid_sb_empty");
    endtask

    task automatic test_small_config();
        int nw;
        int nd;
        logic [25*DW-1:0] w0;
        logic [25*DW-1:0] w1;
        nw = 0;
        nd = 0;
        w0 = '0;
        w1 = '0;
        pix_valid = 1'b0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                s_pix_valid = 1'b1;
                s_pix_data  = DW'(r*10 + c + 1);
                @(posedge clk);
                #1;
                if (s_win_valid === 1'b1) begin
                    if (nw == 0) w0 = s_win_flat;
                    else         w1 = s_win_flat;
`ifdef CONV_WIN_COORD_EN
                    total++;
                    if (int'(s_win_x) !== 0 || int'(s_win_y) !== nw) begin
                        bad++;
                        $display("FAIL small_xy window %0d: got (%0d,%0d) want (0,%0d)",
                                 nw, s_win_x, s_win_y, nw);
                    end
`endif
                    nw++;
                end
                if (s_frame_done === 1'b1) begin
                    nd++;
                    total++;
                    if (s_win_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL small_done_coincident: got win_valid %b want 1", s_win_valid);
                    end
                end
            end
        end
        s_pix_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (s_win_valid !== 1'b0) begin
            bad++;
            $display("FAIL small_idle_valid: got %b want 0", s_win_valid);
        end
        check_scalar("small_windows", nw, 2);
        check_scalar("small_frame_done", nd, 1);
        check_scalar("small_w0_p00", int'(px(w0, 0, 0)), 1);
        check_scalar("small_w0_p44", int'(px(w0, 4, 4)), 45);
        check_scalar("small_w1_p00", int'(px(w1, 0, 0)), 11);
        check_scalar("small_w1_p44", int'(px(w1, 4, 4)), 55);
    endtask

    initial begin
        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        s_pix_valid = 1'b0;
        s_pix_data  = '0;
        clear_stats();
        test_reset();
        test_ramp();
        test_random_duty();
        test_back_to_back();
        test_signed_frame();
        test_reset_midframe();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen_5x5.md
# conv_window_gen_5x5

Streaming 5x5 sliding-window generator that feeds the 5x5 convolution PE. It accepts one signed pixel per cycle in raster order, buffers the four previous image rows, and presents all 25 pixels of every fully-inside (valid-convolution, stride 1, no padding) window with a one-cycle valid strobe. For a 28x28 frame it emits 24x24 = 576 windows, back-to-back frames supported.

## Interface
- DATA_WIDTH, 8, pixel width (signed)
- IMG_W, 28, frame width in pixels (≥ 5)
- IMG_H, 28, frame height in pixels (≥ 5)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pix_valid  in  1  pix_data valid this cycle; no backpressure, always accepted
- pix_data  in  DATA_WIDTH  signed pixel, raster order (row 0 col 0 first)
- win_flat  out  25*DATA_WIDTH  window; p{r}{c} at bits [(r*5+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 oldest (top) row, c=0 leftmost column
- win_valid  out  1  one-cycle strobe, win_flat holds a complete window
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted
- win_x  out  $clog2(IMG_W)  window top-left column (only with CONV_WIN_COORD_EN)
- win_y  out  $clog2(IMG_H)  window top-left row (only with CONV_WIN_COORD_EN)

## Operation
- Counters col (0..IMG_W-1), row (0..IMG_H-1) advance only on pix_valid; col wraps to 0 and row increments at IMG_W-1; at (IMG_H-1, IMG_W-1) both wrap to 0 — next pixel starts a new frame, no idle cycle required.
- 4 line buffers of IMG_W entries each hold rows row-4..row-1 at column index; on accept, read column col from all four, write shifted chain (lb0←pix, lbk←lb(k-1)).
- 5x5 window register: on accept, shift all rows one column left (c0 dropped), load new column c=4 with {lb3, lb2, lb1, lb0, pix} into rows 0..4.
- Window is complete when accepted pixel has row ≥ 4 and col ≥ 4; then win_x = col-4, win_y = row-4.
- Gaps (pix_valid=0): no state change, win_valid=0, win_flat holds last value.
- Line buffer contents are not cleared by reset; stale data can never reach a valid window because all 25 entries are rewritten in-frame before the row ≥ 4, col ≥ 4 condition is met.
- Arithmetic: none on data; pixels pass through bit-exact, sign preserved.

## Timing
- Latency: win_valid/win_flat registered, asserted the cycle after the completing pixel is accepted.
- Throughput: one window per accepted pixel when col ≥ 4 and row ≥ 4.
- frame_done asserts the cycle after the last frame pixel is accepted, coincident with the final win_valid.
- Reset (rst_n=0 sampled at edge): col=0, row=0, win_valid=0, frame_done=0, win_flat=0, win_x=0, win_y=0. Reset mid-frame abandons the frame; next accepted pixel is row 0 col 0.
- pix_valid while rst_n=0: ignored.

## Configuration
- CONV_WIN_COORD_EN defined: win_x/win_y ports and registers present, updated with every win_valid, hold otherwise, reset to 0.
- Undefined: ports and registers absent; all other behaviour identical.

## Test plan
- Ramp frame, pix = (r*28+c) mod 128, pix_valid continuous -> first win_valid one cycle after pixel index 116 accepted; p00=0, p04=4, p40=112, p44=116; exactly 576 win_valid strobes; frame_done once, same cycle as the 576th.
- Same frame with pix_valid random 50% duty -> identical 576-window sequence and contents; win_valid never asserted during or after an idle cycle without a new accept.
- Two frames back-to-back (frame 2 = frame 1 + 1 mod 128) -> no windows mixing frames; frame 2 first window p00=1, p44=117, 576 windows each.
- rst_n low for 1 cycle after 300 pixels, then full ramp frame -> win_valid=0 and win_flat=0 during reset, then exactly the 576 clean-frame windows.
- Small config IMG_W=5, IMG_H=6 -> exactly 2 windows, second window p00 = pixel (1,0), p44 = pixel (5,4).
- CONV_WIN_COORD_EN defined, ramp frame -> win_x/win_y step (0,0),(1,0)…(23,0),(0,1)…(23,23) in lockstep with win_valid.
